// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
package seg_scan_pkg;

  // Default timing: 50000 cycles per digit slot, the first 500 of them dark,
  // and 250 slots per blink half-period.
  localparam int DEF_SLOT_CYCLES  = 50000;
  localparam int DEF_BLANK_CYCLES = 500;
  localparam int DEF_BLINK_SLOTS  = 250;

  // Segments and anodes are both active-low, so all ones means dark.
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // One registered display word: the anode select and the segment bus.
  typedef struct packed {
    logic [7:0] an;
    logic [0:6] seg;
  } disp_t;

  localparam disp_t DISP_OFF = '{an: AN_OFF, seg: SEG_BLANK};

  // Active-low one-hot anode select for a digit index.
  function automatic logic [7:0] an_select(input logic [2:0] idx);
    return ~(8'b1 << idx);
  endfunction

endpackage

// File: rtl/seg_scan_mux_timer.sv
// Slot timing for the scanner: slot counter, end-of-slot strobe, and the
// blink phase that toggles after a fixed number of completed slots.
module scan_timer
  import seg_scan_pkg::*;
#(
  parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int BLINK_SLOTS  = DEF_BLINK_SLOTS
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic slot_start,
  output logic in_blank,
  output logic slot_wrap,
  output logic blink_phase
);

  localparam int CNT_W   = $clog2(SLOT_CYCLES);
  localparam int BLINK_W = $clog2(BLINK_SLOTS + 1);

  localparam logic [CNT_W-1:0]   SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   BLANK_END  = CNT_W'(BLANK_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_SLOTS - 1);

  logic [CNT_W-1:0]   slot_cnt;
  logic [BLINK_W-1:0] blink_cnt;

  // Strobes are decoded from the current count so the top can act on them
  // in the same cycle; a wrap only counts while scanning is enabled.
  assign slot_start = (slot_cnt == '0);
  assign in_blank   = (slot_cnt < BLANK_END);
  assign slot_wrap  = en && (slot_cnt == SLOT_LAST);

  // Slot counter: free-runs 0..SLOT_CYCLES-1 while enabled, parked at 0 otherwise.
  // NOTE: sequential state is always updated with <=, so every register in
  // this process sees the values from before the edge, never a half-updated mix.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
    end else if (!en) begin
      slot_cnt <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Blink counter and phase: phase flips after every BLINK_SLOTS completed
  // slots; disabling scan restarts in the visible phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!en) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (slot_wrap) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Eight-digit time-multiplexed seven-segment driver with per-slot dead-time,
// per-digit blinking and a snapshot of each digit taken at slot start.
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int BLINK_SLOTS  = DEF_BLINK_SLOTS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [0:6] dig0,
  input  logic [0:6] dig1,
  input  logic [0:6] dig2,
  input  logic [0:6] dig3,
  input  logic [0:6] dig4,
  input  logic [0:6] dig5,
  input  logic [0:6] dig6,
  input  logic [0:6] dig7,
  input  logic [7:0] blink_mask,
  output logic [0:6] seg,
  output logic [7:0] an
);

  // Parameter sanity, evaluated at elaboration.
  if (SLOT_CYCLES < 4) begin : g_bad_slot
    $error("seg_scan_mux: SLOT_CYCLES must be at least 4");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES > SLOT_CYCLES - 2) begin : g_bad_blank
    $error("seg_scan_mux: BLANK_CYCLES must be 1..SLOT_CYCLES-2");
  end
  if (BLINK_SLOTS < 1) begin : g_bad_blink
    $error("seg_scan_mux: BLINK_SLOTS must be at least 1");
  end

  logic       slot_start;
  logic       in_blank;
  logic       slot_wrap;
  logic       blink_phase;
  logic [2:0] index;
  logic [0:6] snapshot;
  logic [0:6] dig_sel;
  disp_t      disp_d;
  disp_t      disp_q;

  scan_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES),
    .BLINK_SLOTS (BLINK_SLOTS)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .slot_start (slot_start),
    .in_blank   (in_blank),
    .slot_wrap  (slot_wrap),
    .blink_phase(blink_phase)
  );

  // Pick the pattern of the digit currently being scanned.
  // NOTE: every output of a combinational process gets a default first, so
  // no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    dig_sel = SEG_BLANK;
    unique case (index)
      3'd0: dig_sel = dig0;
      3'd1: dig_sel = dig1;
      3'd2: dig_sel = dig2;
      3'd3: dig_sel = dig3;
      3'd4: dig_sel = dig4;
      3'd5: dig_sel = dig5;
      3'd6: dig_sel = dig6;
      3'd7: dig_sel = dig7;
    endcase
  end

  // Digit index: steps on each slot wrap, back to digit 0 when scan stops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index <= '0;
    end else if (!en) begin
      index <= '0;
    end else if (slot_wrap) begin
      index <= index + 1'b1;
    end
  end

  // Snapshot: freeze the digit pattern at slot start so mid-slot input
  // changes wait for that digit's next slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snapshot <= SEG_BLANK;
    end else if (en && slot_start) begin
      snapshot <= dig_sel;
    end
  end

  // Next display word from the pre-edge counter state: dark when disabled,
  // during dead-time, or during the off phase of a blinking digit.
  always_comb begin
    disp_d = DISP_OFF;
    if (en && !in_blank && !(!blink_phase && blink_mask[index])) begin
      disp_d.an  = an_select(index);
      disp_d.seg = snapshot;
    end
  end

  // Output register: one cycle behind the counters, cleared asynchronously
  // so a reset darkens the display without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q <= DISP_OFF;
    end else begin
      disp_q <= disp_d;
    end
  end

  assign an  = disp_q.an;
  assign seg = disp_q.seg;

endmodule
